// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//  Shared definitions for the unified-memory port arbiter of the MIPS32
//  pipeline: arbiter FSM state encoding, grant-source constants and the
//  default watchdog limit.
// ----------------------------------------------------------------------------
package mips_pkg;

    // Arbiter FSM states; the encoding is fixed so other tooling can decode it
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusyIf = 2'd1,
        StBusyD  = 2'd2,
        StResp   = 2'd3
    } arb_state_e;

    // Which requester owns the current (or just finished) transaction
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    // Watchdog counter width and default limit
    localparam int unsigned WDOG_W           = 8;
    localparam int unsigned MAX_WAIT_DEFAULT = 255;

endpackage

// File: rtl/arb_watchdog.sv
// ----------------------------------------------------------------------------
// arb_watchdog
//  Counts arbiter BUSY cycles spent waiting for mem_ack and flags when the
//  wait limit is hit, so a hung memory cannot freeze the pipeline forever.
// Ports
//  i_clk       rising-edge clock
//  i_rst_n     asynchronous active-low reset
//  i_clear     restart the count (asserted when a transaction is granted)
//  i_enable    a BUSY cycle without mem_ack
//  o_expired   this cycle is the MAX_WAIT-th un-acked BUSY cycle
// ----------------------------------------------------------------------------
module arb_watchdog
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // Count holds the number of un-acked BUSY cycles already completed, so the
    // limit is reached during the cycle in which the count equals MAX_WAIT-1.
    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(MAX_WAIT - 1);

    logic [WDOG_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != {WDOG_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//  Shares one single-ported unified memory between instruction fetch (IF) and
//  load/store (MEM). One requester is granted at a time; data wins ties since
//  it belongs to the older instruction. Each transaction is a req/ack handshake
//  of variable latency, guarded by a watchdog that aborts hung accesses.
// Ports
//  i_clk, i_rst_n            clock, asynchronous active-low reset
//  i_if_req/i_if_addr        fetch request (level, held until o_if_valid)
//  o_if_rdata/o_if_valid     fetched word (registered) and one-cycle done pulse
//  i_d_req/i_d_we/i_d_addr/i_d_wdata   load/store request
//  o_d_rdata/o_d_valid       load data (registered) and one-cycle done pulse
//  o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata   memory request side
//  i_mem_ack/i_mem_rdata     memory completion; rdata valid with ack
//  o_stall_if                freeze PC and IF/ID while a fetch waits
//  o_stall_d                 freeze the whole pipeline while a load/store waits
//  o_timeout_err             sticky watchdog abort flag, cleared by reset only
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_valid,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_valid,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_stall_if,
    output logic              o_stall_d,
    output logic              o_timeout_err
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_gnt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_timeout_err;

    logic              w_load_if;
    logic              w_load_d;
    logic              w_busy;
    logic              w_expired;

    assign w_busy = (r_state == StBusyIf) || (r_state == StBusyD);

    // ------------------------------------------------------------------------
    // Next-state and grant decisions
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_if   = 1'b0;
        w_load_d    = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_d_req) begin
                    w_load_d    = 1'b1;
                    w_state_nxt = StBusyD;
                end else if (i_if_req) begin
                    w_load_if   = 1'b1;
                    w_state_nxt = StBusyIf;
                end
            end
            StBusyIf, StBusyD: begin
                if (i_mem_ack || w_expired) begin
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                // The requester just served still holds its req this cycle;
                // only the other side may be granted, with no IDLE bubble.
                if ((r_gnt == GNT_IF) && i_d_req) begin
                    w_load_d    = 1'b1;
                    w_state_nxt = StBusyD;
                end else if ((r_gnt == GNT_D) && i_if_req) begin
                    w_load_if   = 1'b1;
                    w_state_nxt = StBusyIf;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, latched request and returned data
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_gnt         <= GNT_IF;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_load_d) begin
                r_gnt       <= GNT_D;
                r_mem_we    <= i_d_we;
                r_mem_addr  <= i_d_addr;
                r_mem_wdata <= i_d_we ? i_d_wdata : '0;
            end else if (w_load_if) begin
                r_gnt       <= GNT_IF;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_if_addr;
                r_mem_wdata <= '0;
            end

            // An aborted access returns zero so the stalled stage gets a
            // defined value; a completed store leaves d_rdata untouched.
            if (r_state == StBusyIf) begin
                if (i_mem_ack) begin
                    r_if_rdata <= i_mem_rdata;
                end else if (w_expired) begin
                    r_if_rdata <= '0;
                end
            end
            if (r_state == StBusyD) begin
                if (i_mem_ack) begin
                    if (!r_mem_we) begin
                        r_d_rdata <= i_mem_rdata;
                    end
                end else if (w_expired) begin
                    r_d_rdata <= '0;
                end
            end

            if (w_expired) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    arb_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_load_if | w_load_d),
        .i_enable  (w_busy & ~i_mem_ack),
        .o_expired (w_expired)
    );

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // mem_req follows the state register so reset removes it asynchronously.
    assign o_mem_req     = w_busy;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_if_rdata    = r_if_rdata;
    assign o_d_rdata     = r_d_rdata;
    assign o_if_valid    = (r_state == StResp) && (r_gnt == GNT_IF);
    assign o_d_valid     = (r_state == StResp) && (r_gnt == GNT_D);
    assign o_stall_if    = i_if_req & ~o_if_valid;
    assign o_stall_d     = i_d_req & ~o_d_valid;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//  Directed scenarios plus a randomized run for mem_port_arbiter. A behavioural
//  memory responder with per-requester wait counts drives the memory side; the
//  expected completion cycle of each transaction is derived arithmetically
//  from the wait counts and the watchdog limit.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int          MAXW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] if_rdata, d_rdata;
    logic          if_valid, d_valid;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          stall_if, stall_d, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] dev_mem [0:127];
    logic [31:0] ref_mem [0:127];
    int          w_if, w_d;
    bit          resp_en, spur_ack;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    bit          exp_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MAXW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_if_req      (if_req),
        .i_if_addr     (if_addr),
        .o_if_rdata    (if_rdata),
        .o_if_valid    (if_valid),
        .i_d_req       (d_req),
        .i_d_we        (d_we),
        .i_d_addr      (d_addr),
        .i_d_wdata     (d_wdata),
        .o_d_rdata     (d_rdata),
        .o_d_valid     (d_valid),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_ack     (mem_ack),
        .i_mem_rdata   (mem_rdata),
        .o_stall_if    (stall_if),
        .o_stall_d     (stall_d),
        .o_timeout_err (timeout_err)
    );

    function automatic int widx(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    // Cycles from request (cycle 0) to the valid pulse for a given wait count
    function automatic int lat(input int w);
        return (w < MAXW) ? w + 2 : MAXW + 1;
    endfunction

    // Memory model: acks after the requester's wait count, combinational rdata
    initial begin : responder
        int bcnt;
        int cur_wait;
        bcnt      = 0;
        cur_wait  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req && resp_en) begin
                if (bcnt == 0) cur_wait = (mem_addr == if_addr) ? w_if : w_d;
                if (bcnt == cur_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = dev_mem[widx(mem_addr)];
                    if (mem_we) dev_mem[widx(mem_addr)] = mem_wdata;
                    bcnt = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'h5A5A_5A5A;
                    bcnt++;
                end
            end else begin
                bcnt      = 0;
                mem_ack   = spur_ack;
                mem_rdata = spur_ack ? 32'hDEAD_BEEF : '0;
            end
        end
    end

    initial begin : global_timeout
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Drive point: 4 time units after the rising edge
    task automatic cyc();
        @(posedge clk);
        #4;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        resp_en = 1; spur_ack = 0;
        repeat (2) cyc();
        n_tests++; if (mem_req !== 1'b0) begin n_fail++;
            $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_tests++; if ({if_valid, d_valid} !== 2'b00) begin n_fail++;
            $display("FAIL reset_valid: got %b want 00", {if_valid, d_valid}); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++;
            $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        n_tests++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++;
            $display("FAIL reset_rdata: got %h want 0", {if_rdata, d_rdata}); end
        n_tests++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin n_fail++;
            $display("FAIL reset_mem_bus: got %h want 0", {mem_we, mem_addr, mem_wdata}); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_err = 0;
    endtask

    task automatic test_fetch_alone();
        dev_mem[1] = 32'h8C01_0000;
        w_if = 2;
        cyc();
        if_addr = 32'h04; if_req = 1;
        #1;
        n_tests++; if (stall_if !== 1'b1) begin n_fail++;
            $display("FAIL fetch_stall_c0: got %b want 1", stall_if); end
        for (int c = 1; c <= 5; c++) begin
            cyc();
            n_tests++; if (if_valid !== (c == 4)) begin n_fail++;
                $display("FAIL fetch_valid_c%0d: got %b want %b", c, if_valid, c == 4); end
            n_tests++; if (stall_if !== (c < 4)) begin n_fail++;
                $display("FAIL fetch_stall_c%0d: got %b want %b", c, stall_if, c < 4); end
            n_tests++; if (mem_req !== (c <= 3)) begin n_fail++;
                $display("FAIL fetch_mem_req_c%0d: got %b want %b", c, mem_req, c <= 3); end
            if (c <= 3) begin
                n_tests++; if ({mem_we, mem_addr} !== {1'b0, 32'h04}) begin n_fail++;
                    $display("FAIL fetch_mem_bus_c%0d: got %b/%h want 0/00000004",
                             c, mem_we, mem_addr); end
            end
            if (c == 4) begin
                n_tests++; if (if_rdata !== 32'h8C01_0000) begin n_fail++;
                    $display("FAIL fetch_rdata: got %h want 8c010000", if_rdata); end
                if_req = 0;
                exp_if_rdata = 32'h8C01_0000;
            end
        end
    endtask

    task automatic test_tie();
        dev_mem[16] = 32'h00A0_0040;
        dev_mem[2]  = 32'h2402_0007;
        w_d = 0; w_if = 0;
        cyc();
        if_addr = 32'h08; if_req = 1;
        d_addr = 32'h40; d_we = 0; d_wdata = 32'hFFFF_FFFF; d_req = 1;
        cyc();
        n_tests++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b10, 32'h40, 32'h0}) begin
            n_fail++; $display("FAIL tie_grant_data: got req=%b we=%b addr=%h wdata=%h want 1/0/40/0",
                               mem_req, mem_we, mem_addr, mem_wdata); end
        cyc();
        n_tests++; if ({d_valid, if_valid, d_rdata} !== {2'b10, 32'h00A0_0040}) begin n_fail++;
            $display("FAIL tie_d_done: got dv=%b iv=%b rdata=%h want 1/0/00a00040",
                     d_valid, if_valid, d_rdata); end
        d_req = 0;
        exp_d_rdata = 32'h00A0_0040;
        cyc();
        n_tests++; if ({mem_req, mem_addr} !== {1'b1, 32'h08}) begin n_fail++;
            $display("FAIL tie_no_bubble: got req=%b addr=%h want 1/08", mem_req, mem_addr); end
        cyc();
        n_tests++; if ({if_valid, if_rdata} !== {1'b1, 32'h2402_0007}) begin n_fail++;
            $display("FAIL tie_if_done: got v=%b rdata=%h want 1/24020007", if_valid, if_rdata); end
        if_req = 0;
        exp_if_rdata = 32'h2402_0007;
    endtask

    task automatic test_store();
        w_d = 1;
        cyc();
        d_we = 1; d_addr = 32'h10; d_wdata = 32'h1234; d_req = 1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c <= 2) begin
                n_tests++; if ({mem_req, mem_we, mem_addr, mem_wdata} !==
                               {2'b11, 32'h10, 32'h1234}) begin n_fail++;
                    $display("FAIL store_bus_c%0d: got req=%b we=%b addr=%h wdata=%h want 1/1/10/1234",
                             c, mem_req, mem_we, mem_addr, mem_wdata); end
            end else begin
                n_tests++; if ({d_valid, d_rdata} !== {1'b1, exp_d_rdata}) begin n_fail++;
                    $display("FAIL store_done: got v=%b rdata=%h want 1/%h",
                             d_valid, d_rdata, exp_d_rdata); end
            end
        end
        d_req = 0; d_we = 0;
        n_tests++; if (dev_mem[4] !== 32'h1234) begin n_fail++;
            $display("FAIL store_mem_written: got %h want 00001234", dev_mem[4]); end
    endtask

    task automatic test_hung();
        resp_en = 0;
        cyc();
        d_we = 0; d_addr = 32'h20; d_req = 1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            n_tests++; if (mem_req !== (c <= 4)) begin n_fail++;
                $display("FAIL hung_mem_req_c%0d: got %b want %b", c, mem_req, c <= 4); end
            n_tests++; if (timeout_err !== (c == 5)) begin n_fail++;
                $display("FAIL hung_err_c%0d: got %b want %b", c, timeout_err, c == 5); end
            if (c == 5) begin
                n_tests++; if ({d_valid, d_rdata} !== {1'b1, 32'h0}) begin n_fail++;
                    $display("FAIL hung_done: got v=%b rdata=%h want 1/0", d_valid, d_rdata); end
            end
        end
        d_req = 0;
        exp_d_rdata = '0;
        repeat (3) cyc();
        n_tests++; if ({timeout_err, d_valid} !== 2'b10) begin n_fail++;
            $display("FAIL hung_err_sticky: got err=%b v=%b want 1/0", timeout_err, d_valid); end
        resp_en = 1;
    endtask

    task automatic test_reset_mid_busy();
        bit seen_valid;
        resp_en = 0;
        cyc();
        d_we = 0; d_addr = 32'h30; d_req = 1;
        repeat (2) cyc();
        #2;
        rst_n = 0;
        #1;
        n_tests++; if ({mem_req, timeout_err} !== 2'b00) begin n_fail++;
            $display("FAIL rstmid_async: got req=%b err=%b want 0/0", mem_req, timeout_err); end
        d_req = 0;
        resp_en = 1;
        @(negedge clk);
        rst_n = 1;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_err = 0;
        seen_valid = 0;
        repeat (3) begin
            cyc();
            if (if_valid || d_valid || mem_req) seen_valid = 1;
        end
        n_tests++; if (seen_valid) begin n_fail++;
            $display("FAIL rstmid_quiet: got activity after reset want none"); end
        w_if = 0;
        if_addr = 32'h08; if_req = 1;
        cyc();
        n_tests++; if ({mem_req, mem_addr} !== {1'b1, 32'h08}) begin n_fail++;
            $display("FAIL rstmid_regrant: got req=%b addr=%h want 1/08", mem_req, mem_addr); end
        cyc();
        n_tests++; if ({if_valid, if_rdata} !== {1'b1, dev_mem[2]}) begin n_fail++;
            $display("FAIL rstmid_fetch: got v=%b rdata=%h want 1/%h",
                     if_valid, if_rdata, dev_mem[2]); end
        if_req = 0;
        exp_if_rdata = dev_mem[2];
    endtask

    task automatic test_spurious_ack();
        cyc();
        spur_ack = 1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_tests++; if ({mem_req, if_valid, d_valid, stall_if, stall_d, timeout_err} !== 6'b0)
            begin n_fail++;
                $display("FAIL spur_ctrl_c%0d: got %b want 000000", c,
                         {mem_req, if_valid, d_valid, stall_if, stall_d, timeout_err}); end
            n_tests++; if ({if_rdata, d_rdata} !== {exp_if_rdata, exp_d_rdata}) begin n_fail++;
                $display("FAIL spur_rdata_c%0d: got %h/%h want %h/%h", c,
                         if_rdata, d_rdata, exp_if_rdata, exp_d_rdata); end
        end
        spur_ack = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 128; i++) ref_mem[i] = dev_mem[i];
        for (int it = 0; it < 60; it++) begin
            int          kind, tif, td;
            bit          want_if, want_d, got_if, got_d;
            logic [31:0] ia, da, dwd, eif, ed;
            bit          dwe;
            kind = int'($urandom_range(0, 2));
            ia   = {22'd0, 6'($urandom_range(0, 63)), 2'b00};
            da   = 32'h100 + {22'd0, 6'($urandom_range(0, 63)), 2'b00};
            dwe  = 1'($urandom_range(0, 1));
            dwd  = $urandom;
            w_if = int'($urandom_range(0, 5));
            w_d  = int'($urandom_range(0, 5));
            want_if = (kind != 1);
            want_d  = (kind != 0);
            td  = lat(w_d);
            tif = (kind == 2) ? td + lat(w_if) : lat(w_if);
            eif = (w_if >= MAXW) ? 32'h0 : ref_mem[widx(ia)];
            if (want_if) exp_err |= (w_if >= MAXW);
            ed = exp_d_rdata;
            if (want_d) begin
                if (w_d >= MAXW) ed = 32'h0;
                else if (!dwe)   ed = ref_mem[widx(da)];
                else             ref_mem[widx(da)] = dwd;
                exp_err |= (w_d >= MAXW);
            end
            cyc();
            if_addr = ia; d_addr = da; d_we = dwe; d_wdata = dwd;
            if_req = want_if; d_req = want_d;
            got_if = 0; got_d = 0;
            for (int c = 1; c <= 40 && ((want_if && !got_if) || (want_d && !got_d)); c++) begin
                cyc();
                if (if_valid) begin
                    n_tests++; if (!(want_if && !got_if && c == tif)) begin n_fail++;
                        $display("FAIL rnd%0d_if_timing: got valid at cycle %0d want %0d",
                                 it, c, want_if ? tif : -1); end
                    n_tests++; if (if_rdata !== eif) begin n_fail++;
                        $display("FAIL rnd%0d_if_rdata: got %h want %h", it, if_rdata, eif); end
                    got_if = 1; if_req = 0;
                end
                if (d_valid) begin
                    n_tests++; if (!(want_d && !got_d && c == td)) begin n_fail++;
                        $display("FAIL rnd%0d_d_timing: got valid at cycle %0d want %0d",
                                 it, c, want_d ? td : -1); end
                    n_tests++; if (d_rdata !== ed) begin n_fail++;
                        $display("FAIL rnd%0d_d_rdata: got %h want %h", it, d_rdata, ed); end
                    got_d = 1; d_req = 0;
                end
            end
            n_tests++; if ((want_if && !got_if) || (want_d && !got_d)) begin n_fail++;
                $display("FAIL rnd%0d_complete: got if=%b d=%b want if=%b d=%b",
                         it, got_if, got_d, want_if, want_d); end
            if_req = 0; d_req = 0;
            exp_d_rdata = ed;
            if (want_if) exp_if_rdata = eif;
            n_tests++; if (timeout_err !== exp_err) begin n_fail++;
                $display("FAIL rnd%0d_timeout_err: got %b want %b", it, timeout_err, exp_err); end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) dev_mem[i] = $urandom;
        w_if = 0; w_d = 0;
        resp_en = 1; spur_ack = 0;
        test_reset();
        test_fetch_alone();
        test_tie();
        test_store();
        test_hung();
        test_reset_mid_busy();
        test_spurious_ack();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
